// File: rtl/ps2_scan_sequencer_pkg.sv
// ==========================================================================
// ps2_pkg : shared constants and types for the PS/2 scan-code sequencer
// Revision: 1.0
// ==========================================================================
`default_nettype none

package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
    localparam logic [7:0] PS2_ERR_LO  = 8'h00;
    localparam logic [7:0] PS2_ERR_HI  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        DECODE = 2'd2,
        EMIT   = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

endpackage

`default_nettype wire

// File: rtl/ps2_scan_sequencer.sv
// ==========================================================================
// ps2_scan_sequencer : pops PS/2 bytes, folds E0/F0 prefixes into key events
// Optional typematic-repeat filter: define PS2_SEQ_REPEAT_FILTER_EN
// Revision: 1.0
// ==========================================================================
`default_nettype none

module ps2_scan_sequencer
    import ps2_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int ACK_GAP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_ready,
    input  logic             rx_overflow,
    output logic             rx_nextdata_n,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic [CNT_W-1:0] press_count,
    output logic             rx_ovf_sticky,
    output logic             err_pulse
);

    localparam logic [1:0]       C_GAP_LAST = 2'(ACK_GAP - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_t       r_state, w_state_next;
    logic [7:0]       r_byte, w_byte;
    logic             r_ext_f, w_ext_f;
    logic             r_brk_f, w_brk_f;
    logic [1:0]       r_gap, w_gap;
    key_event_t       r_evt, w_evt;
    logic             r_ev_valid, w_ev_valid;
    logic             r_nextdata_n, w_nextdata_n;
    logic [CNT_W-1:0] r_press_count, w_press_count;
    logic             r_ovf;
    logic             r_err, w_err;

`ifdef PS2_SEQ_REPEAT_FILTER_EN
    logic [7:0] r_held_code, w_held_code;
    logic       r_held_ext, w_held_ext;
    logic       r_held_vld, w_held_vld;
    logic       w_held_match;

    assign w_held_match = r_held_vld && (r_held_code == r_byte) && (r_held_ext == r_ext_f);
`endif

    always_comb begin
        w_state_next  = r_state;
        w_byte        = r_byte;
        w_ext_f       = r_ext_f;
        w_brk_f       = r_brk_f;
        w_gap         = r_gap;
        w_evt         = r_evt;
        w_ev_valid    = r_ev_valid;
        w_nextdata_n  = 1'b1;
        w_press_count = r_press_count;
        w_err         = 1'b0;
`ifdef PS2_SEQ_REPEAT_FILTER_EN
        w_held_code   = r_held_code;
        w_held_ext    = r_held_ext;
        w_held_vld    = r_held_vld;
`endif
        case (r_state)
            IDLE: begin
                if (rx_ready) begin
                    w_byte       = rx_data;
                    w_nextdata_n = 1'b0;
                    w_gap        = 2'd0;
                    w_state_next = ACK;
                end
            end
            // The pop-pulse cycle counts as the first gap cycle
            ACK: begin
                if (r_gap == C_GAP_LAST) begin
                    w_state_next = DECODE;
                end else begin
                    w_gap = r_gap + 2'd1;
                end
            end
            DECODE: begin
                w_state_next = IDLE;
                if (r_byte == PS2_PFX_EXT) begin
                    w_ext_f = 1'b1;
                end else if (r_byte == PS2_PFX_BRK) begin
                    w_brk_f = 1'b1;
                end else begin
                    w_ext_f = 1'b0;
                    w_brk_f = 1'b0;
                    if (r_byte == PS2_ERR_LO || r_byte == PS2_ERR_HI) begin
                        w_err = 1'b1;
`ifdef PS2_SEQ_REPEAT_FILTER_EN
                    end else if (!r_brk_f && w_held_match) begin
                        w_state_next = IDLE;
`endif
                    end else begin
                        w_evt.code   = r_byte;
                        w_evt.ext    = r_ext_f;
                        w_evt.brk    = r_brk_f;
                        w_ev_valid   = 1'b1;
                        w_state_next = EMIT;
`ifdef PS2_SEQ_REPEAT_FILTER_EN
                        if (!r_brk_f) begin
                            w_held_code = r_byte;
                            w_held_ext  = r_ext_f;
                            w_held_vld  = 1'b1;
                        end else if (w_held_match) begin
                            w_held_vld  = 1'b0;
                        end
`endif
                    end
                end
            end
            EMIT: begin
                if (ev_ready) begin
                    w_ev_valid   = 1'b0;
                    w_state_next = IDLE;
                    if (!r_evt.brk) begin
                        w_press_count = r_press_count + C_CNT_ONE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte        <= 8'h00;
            r_ext_f       <= 1'b0;
            r_brk_f       <= 1'b0;
            r_gap         <= 2'd0;
            r_evt         <= '0;
            r_ev_valid    <= 1'b0;
            r_nextdata_n  <= 1'b1;
            r_press_count <= '0;
            r_ovf         <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_byte        <= w_byte;
            r_ext_f       <= w_ext_f;
            r_brk_f       <= w_brk_f;
            r_gap         <= w_gap;
            r_evt         <= w_evt;
            r_ev_valid    <= w_ev_valid;
            r_nextdata_n  <= w_nextdata_n;
            r_press_count <= w_press_count;
            r_ovf         <= r_ovf | rx_overflow;
            r_err         <= w_err;
        end
    end

`ifdef PS2_SEQ_REPEAT_FILTER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_held_code <= 8'h00;
            r_held_ext  <= 1'b0;
            r_held_vld  <= 1'b0;
        end else begin
            r_held_code <= w_held_code;
            r_held_ext  <= w_held_ext;
            r_held_vld  <= w_held_vld;
        end
    end
`endif

    assign rx_nextdata_n = r_nextdata_n;
    assign ev_valid      = r_ev_valid;
    assign ev_code       = r_evt.code;
    assign ev_ext        = r_evt.ext;
    assign ev_break      = r_evt.brk;
    assign press_count   = r_press_count;
    assign rx_ovf_sticky = r_ovf;
    assign err_pulse     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scan_sequencer.sv
// Directed self-checking bench for ps2_scan_sequencer (both filter builds).
`default_nettype none

module tb_ps2_scan_sequencer;

    localparam int CNT_W   = 8;
    localparam int ACK_GAP = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_ready;
    logic             rx_overflow;
    logic             rx_nextdata_n;
    logic             ev_valid;
    logic             ev_ready;
    logic [7:0]       ev_code;
    logic             ev_ext;
    logic             ev_break;
    logic [CNT_W-1:0] press_count;
    logic             rx_ovf_sticky;
    logic             err_pulse;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc     = 0;
    int pop_cnt = 0;
    int err_cnt = 0;
    int ev_cnt  = 0;

    always #5 clk = ~clk;

    ps2_scan_sequencer #(.CNT_W(CNT_W), .ACK_GAP(ACK_GAP)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .rx_overflow  (rx_overflow),
        .rx_nextdata_n(rx_nextdata_n),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_code      (ev_code),
        .ev_ext       (ev_ext),
        .ev_break     (ev_break),
        .press_count  (press_count),
        .rx_ovf_sticky(rx_ovf_sticky),
        .err_pulse    (err_pulse)
    );

    // Pre-edge values seen at each rising edge
    always @(posedge clk) begin
        cyc++;
        if (!rx_nextdata_n) pop_cnt++;
        if (err_pulse) err_cnt++;
        if (ev_valid && ev_ready) ev_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        logic got;
        got      = 1'b0;
        rx_data  = b;
        rx_ready = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (!rx_nextdata_n) got = 1'b1;
        end
        rx_ready = 1'b0;
        check("pop_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic expect_event(input string tag, input logic [7:0] code,
                                input logic ext, input logic brk);
        for (int i = 0; i < 30 && !ev_valid; i++) @(negedge clk);
        check(tag, {21'd0, ev_valid, ev_ext, ev_break, ev_code}, {21'd0, 1'b1, ext, brk, code});
    endtask

    initial begin
        int t0, p0, e0, v0;
        rst = 1'b1; rx_data = 8'h00; rx_ready = 1'b0; rx_overflow = 1'b0; ev_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_nextdata_n", {31'd0, rx_nextdata_n}, 32'd1);
        check("rst_ev_valid",   {31'd0, ev_valid}, 32'd0);
        check("rst_ev_code",    {24'd0, ev_code}, 32'd0);
        check("rst_ev_ext",     {31'd0, ev_ext}, 32'd0);
        check("rst_ev_break",   {31'd0, ev_break}, 32'd0);
        check("rst_press_count", {24'd0, press_count}, 32'd0);
        check("rst_ovf_sticky", {31'd0, rx_ovf_sticky}, 32'd0);
        check("rst_err_pulse",  {31'd0, err_pulse}, 32'd0);
        rst = 1'b0;
        ev_ready = 1'b1;
        @(negedge clk);

        // Plain press, with latency and pop-pulse count
        t0 = cyc; p0 = pop_cnt;
        push_byte(8'h1C);
        expect_event("press_1c", 8'h1C, 1'b0, 1'b0);
        check("latency", cyc - t0, 2 + ACK_GAP);
        @(negedge clk);
        check("press_cnt_1", {24'd0, press_count}, 32'd1);
        check("pops_1", pop_cnt - p0, 32'd1);

        // Release
        p0 = pop_cnt;
        push_byte(8'hF0);
        push_byte(8'h1C);
        expect_event("release_1c", 8'h1C, 1'b0, 1'b1);
        @(negedge clk);
        check("press_cnt_rel", {24'd0, press_count}, 32'd1);
        check("pops_2", pop_cnt - p0, 32'd2);

        // Extended release held off by back-pressure
        ev_ready = 1'b0;
        push_byte(8'hE0);
        push_byte(8'hF0);
        push_byte(8'h75);
        expect_event("ext_rel_75", 8'h75, 1'b1, 1'b1);
        p0 = pop_cnt; v0 = ev_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_hold", {21'd0, ev_valid, ev_ext, ev_break, ev_code}, {21'd0, 1'b1, 1'b1, 1'b1, 8'h75});
            check("stall_nextdata_n", {31'd0, rx_nextdata_n}, 32'd1);
        end
        ev_ready = 1'b1;
        @(negedge clk);
        check("stall_accept", {31'd0, ev_valid}, 32'd0);
        check("stall_ev_cnt", ev_cnt - v0, 32'd1);
        check("stall_pops", pop_cnt - p0, 32'd0);
        check("press_cnt_ext", {24'd0, press_count}, 32'd1);

        // Error byte then a normal press
        e0 = err_cnt; v0 = ev_cnt;
        push_byte(8'hFF);
        repeat (4) @(negedge clk);
        check("err_pulse_cnt", err_cnt - e0, 32'd1);
        check("err_no_event", ev_cnt - v0, 32'd0);
        push_byte(8'h1C);
        expect_event("press_after_err", 8'h1C, 1'b0, 1'b0);
        @(negedge clk);
        check("press_cnt_2", {24'd0, press_count}, 32'd2);

        // Sticky overflow, then reset while the E0 byte is in DECODE
        rx_overflow = 1'b1;
        @(negedge clk);
        rx_overflow = 1'b0;
        @(negedge clk);
        check("ovf_set", {31'd0, rx_ovf_sticky}, 32'd1);
        push_byte(8'hE0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ovf_cleared", {31'd0, rx_ovf_sticky}, 32'd0);
        check("press_cnt_rst", {24'd0, press_count}, 32'd0);
        push_byte(8'h74);
        expect_event("no_ext_after_rst", 8'h74, 1'b0, 1'b0);
        @(negedge clk);
        check("press_cnt_74", {24'd0, press_count}, 32'd1);

        // 256 alternating presses wrap the counter back to its start value
        for (int i = 0; i < 256; i++) begin
            push_byte(i[0] ? 8'h1C : 8'h1D);
            expect_event("wrap_press", i[0] ? 8'h1C : 8'h1D, 1'b0, 1'b0);
        end
        @(negedge clk);
        check("press_cnt_wrap", {24'd0, press_count}, 32'd1);

        // Typematic sequence 1C,1C,1C,F0,1C
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        v0 = ev_cnt;
        push_byte(8'h1C);
        push_byte(8'h1C);
        push_byte(8'h1C);
        push_byte(8'hF0);
        push_byte(8'h1C);
        repeat (10) @(negedge clk);
`ifdef PS2_SEQ_REPEAT_FILTER_EN
        check("repeat_events", ev_cnt - v0, 32'd2);
        check("repeat_press_cnt", {24'd0, press_count}, 32'd1);
`else
        check("repeat_events", ev_cnt - v0, 32'd4);
        check("repeat_press_cnt", {24'd0, press_count}, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/ps2_scan_sequencer.md
Name: ps2_scan_sequencer

Overview:
- Controller between the PS/2 receiver FIFO (ps2_keyboard: data/ready/overflow/nextdata_n) and downstream consumers.
- Pops bytes one at a time through the nextdata_n handshake and parses the E0/F0 prefixes into single key events.
- Presents each event on a valid/ready interface and keeps a running press counter plus a sticky overflow flag.

Parameters:
- CNT_W, 8, width of press_count; counter wraps modulo 2^CNT_W.
- ACK_GAP, 1, idle cycles after the nextdata_n pulse before rx_ready is sampled again (range 1..3).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_data  in  8  head byte of receiver FIFO
- rx_ready  in  1  FIFO non-empty
- rx_overflow  in  1  receiver FIFO overflowed
- rx_nextdata_n  out  1  active-low pop strobe to receiver; one-cycle pulse
- ev_valid  out  1  event available
- ev_ready  in  1  consumer accepts event
- ev_code  out  8  scan code, prefixes stripped
- ev_ext  out  1  code was E0-prefixed
- ev_break  out  1  1 = release, 0 = press
- press_count  out  CNT_W  number of press events accepted by the consumer
- rx_ovf_sticky  out  1  set on rx_overflow; cleared only by rst
- err_pulse  out  1  one-cycle pulse on error byte 00 or FF

Behaviour:
- Reset values:
  - rx_nextdata_n=1; ev_valid=0; ev_code=0; ev_ext=0; ev_break=0.
  - press_count=0; rx_ovf_sticky=0; err_pulse=0.
  - Prefix flags ext_f=0, brk_f=0; FSM=IDLE.
- All outputs are registered.
- FSM states:
  - IDLE: if rx_ready=1, latch rx_data into byte_q, drive rx_nextdata_n=0 next cycle, go to ACK. If rx_ready=0, stay.
  - ACK: rx_nextdata_n=0 for exactly this cycle, then back to 1. Wait ACK_GAP cycles, then go to DECODE.
  - DECODE (one cycle):
    - E0: set ext_f, go to IDLE.
    - F0: set brk_f, go to IDLE.
    - 00 or FF: clear both flags, pulse err_pulse, go to IDLE.
    - Any other byte: load ev_code=byte_q, ev_ext=ext_f, ev_break=brk_f; clear flags; set ev_valid; go to EMIT.
  - EMIT: hold all ev_* stable while ev_valid=1 and ev_ready=0. On ev_valid&&ev_ready: clear ev_valid; if ev_break=0, press_count+1; go to IDLE.
- No new byte is popped while in ACK, DECODE or EMIT, so back-pressure stalls the receiver FIFO rather than dropping bytes.
- Latency: rx_ready high in IDLE at cycle N produces ev_valid at cycle N+2+ACK_GAP.
- Prefix ordering:
  - E0,F0,xx and F0,xx are both accepted.
  - F0,E0,xx is also accepted; the flags are order-independent.
  - Repeated prefixes are idempotent.
- press_count wraps from 2^CNT_W-1 to 0 with no flag.
- rx_overflow is sampled every cycle in any state and ORed into rx_ovf_sticky. It does not alter FSM flow.
- rst mid-sequence (any state): return to reset values next edge. A pending event is discarded and partial prefixes are dropped.
- ev_ready asserted while ev_valid=0 is ignored.

Optional Feature:
- Macro PS2_SEQ_REPEAT_FILTER_EN.
- Defined:
  - Registers held_code[7:0], held_ext, held_vld (reset 0).
  - A press whose {code,ext} equals the held key while held_vld=1 is typematic repeat. It is suppressed: no EMIT, no count, and the FSM returns to IDLE.
  - Any other press loads the held key and sets held_vld.
  - A release matching the held key clears held_vld. The release event is still emitted.
- Undefined: every press is emitted and counted; the held registers are absent.

Decomposition:
- Package ps2_pkg holds:
  - Constants PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, PS2_ERR_LO=8'h00, PS2_ERR_HI=8'hFF.
  - Enum seq_state_t {IDLE, ACK, DECODE, EMIT}.
  - Packed struct key_event_t {ext, brk, code[7:0]}.
- No sub-module. Prefix decode is a few compares inside DECODE and does not justify its own module.

Test Plan:
- Feed 1C with ev_ready=1: one rx_nextdata_n low pulse; event {code=1C, ext=0, brk=0}; press_count 0→1.
- Feed F0,1C: two pop pulses, one event {1C, ext=0, brk=1}; press_count unchanged.
- Feed E0,F0,75 with ev_ready held 0 for 10 cycles: ev_* stable for 10 cycles; no rx_nextdata_n pulse while stalled; accepted on the first ev_ready=1 cycle.
- Feed FF, then 1C: err_pulse high for exactly one cycle, no event for FF; next event {1C, ext=0, brk=0}.
- Assert rx_overflow one cycle; assert rst in DECODE after E0: rx_ovf_sticky=1 before rst and 0 after. A subsequent 74 yields ext=0.
- Pulse 256 presses with CNT_W=8: press_count returns to 0. With PS2_SEQ_REPEAT_FILTER_EN, 1C,1C,1C,F0,1C yields exactly two events (1 press, 1 release) and press_count=1.
